// File: rtl/pump_scheduler_pkg.sv
// Shared types and helpers for the pump scheduler: FSM state encoding,
// millisecond tick sizing and the round-robin requester pick.
package pump_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPEN  = 3'd1,
    RUN   = 3'd2,
    CLOSE = 3'd3,
    REST  = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam int MAX_REQ = 8;

  function automatic int ms_to_cyc(input int clk_hz);
    int c;
    c = clk_hz / 1000;
    if (c < 1) c = 1;
    return c;
  endfunction

  // One-hot of the first eligible bit at or after ptr, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] elig,
                                                 input logic [2:0]         ptr,
                                                 input int                 n);
    logic [MAX_REQ-1:0] oh;
    logic [2:0]         idx;
    logic               found;
    oh    = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = 3'((int'(ptr) + k) % n);
        if (!found && elig[idx]) begin
          oh[idx] = 1'b1;
          found   = 1'b1;
        end
      end
    end
    return oh;
  endfunction

  function automatic logic [2:0] oh_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (oh[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pump_scheduler_if.sv
// Bundle between the cistern controllers (master) and the pump scheduler (slave).
interface pump_scheduler_if #(
  parameter int N_REQ = 4
);
  import pump_sched_pkg::*;

  // req is a level, not a handshake: a requester holds it high for as long as
  // it wants water; the scheduler grants by raising that requester's valve bit.
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] req_fault;
  logic             clr_fault;
  logic [N_REQ-1:0] valve_open;
  logic             pump_on;
  logic             busy;
  logic [2:0]       served_idx;
  logic             sched_fault;
  state_t           state_dbg;

  modport master (
    output req, req_fault, clr_fault,
    input  valve_open, pump_on, busy, served_idx, sched_fault, state_dbg
  );

  modport slave (
    input  req, req_fault, clr_fault,
    output valve_open, pump_on, busy, served_idx, sched_fault, state_dbg
  );

endinterface

// File: rtl/pump_scheduler_ms_timer.sv
// Millisecond prescaler plus saturating ms counter, cleared by restart.
module ms_timer #(
  parameter int TICK_CYC = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  output logic [CNT_W-1:0] ms_count,
  output logic             tick
);

  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [PW-1:0]    presc_q, presc_d;
  logic [CNT_W-1:0] ms_q, ms_d;

  assign tick     = (presc_q == PW'(TICK_CYC - 1));
  assign ms_count = ms_q;

  always_comb begin
    presc_d = presc_q;
    ms_d    = ms_q;
    if (restart) begin
      presc_d = '0;
      ms_d    = '0;
    end else if (tick) begin
      presc_d = '0;
      if (ms_q != '1) ms_d = ms_q + 1'b1;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else begin
      presc_q <= presc_d;
      ms_q    <= ms_d;
    end
  end

endmodule

// File: rtl/pump_scheduler.sv
// Round-robin sharing of one pump among N_REQ cisterns with valve settle,
// min-run and min-rest timing. PUMP_SCHED_MAXRUN_EN adds a run watchdog.
module pump_scheduler
  import pump_sched_pkg::*;
#(
  parameter int CLK_HZ          = 25_000_000,
  parameter int N_REQ           = 4,
  parameter int VALVE_SETTLE_MS = 200,
  parameter int MIN_RUN_MS      = 2000,
  parameter int MIN_REST_MS     = 5000,
  parameter int MAX_RUN_MS      = 60000
) (
  input  logic              clk,
  input  logic              rst_n,
  pump_scheduler_if.slave   bus
);

  localparam int TICK_CYC = ms_to_cyc(CLK_HZ);
  localparam int MAX_A    = (MIN_RUN_MS > MAX_RUN_MS) ? MIN_RUN_MS : MAX_RUN_MS;
  localparam int MAX_B    = (VALVE_SETTLE_MS > MIN_REST_MS) ? VALVE_SETTLE_MS : MIN_REST_MS;
  localparam int MAX_MS   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W    = $clog2(MAX_MS + 1);

  localparam logic [CNT_W:0] SETTLE_T = (CNT_W+1)'(VALVE_SETTLE_MS);
  localparam logic [CNT_W:0] MINRUN_T = (CNT_W+1)'(MIN_RUN_MS);
  localparam logic [CNT_W:0] REST_T   = (CNT_W+1)'(MIN_REST_MS);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] valve_q, valve_d;
  logic             pump_q, pump_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;

  logic [CNT_W-1:0] ms_count;
  logic             tick;
  logic [CNT_W:0]   elapsed;
  logic [N_REQ-1:0] eligible;
  logic [2:0]       pick_idx;
  logic [2:0]       next_ptr;
  logic             cur_req, cur_fault;

  ms_timer #(.TICK_CYC(TICK_CYC), .CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (state_d != state_q),
    .ms_count (ms_count),
    .tick     (tick)
  );

  // Milliseconds completed once this cycle ends; leaving when it reaches K
  // makes a K ms state last exactly K ticks from its entry cycle.
  assign elapsed  = {1'b0, ms_count} + {{CNT_W{1'b0}}, tick};
  assign eligible = bus.req & ~bus.req_fault;
  assign pick_idx = oh_to_idx(rr_pick(MAX_REQ'(eligible), rr_ptr_q, N_REQ));
  assign next_ptr = (idx_q == 3'(N_REQ - 1)) ? 3'd0 : idx_q + 3'd1;
  // valve_q is the one-hot of idx_q whenever a requester is being served.
  assign cur_req   = |(bus.req & valve_q);
  assign cur_fault = |(bus.req_fault & valve_q);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d = OPEN;
          idx_d   = pick_idx;
        end
      end
      OPEN: begin
        if (cur_fault)               state_d = CLOSE;
        else if (elapsed >= SETTLE_T) state_d = RUN;
      end
      RUN: begin
        if (cur_fault) state_d = CLOSE;
`ifdef PUMP_SCHED_MAXRUN_EN
        else if (elapsed >= (CNT_W+1)'(MAX_RUN_MS)) state_d = FAULT;
`endif
        else if (!cur_req && elapsed >= MINRUN_T) state_d = CLOSE;
      end
      CLOSE: begin
        if (elapsed >= SETTLE_T) begin
          state_d  = REST;
          rr_ptr_d = next_ptr;
        end
      end
      REST: begin
        if (elapsed >= REST_T) state_d = IDLE;
      end
      FAULT: begin
        if (bus.clr_fault) begin
          state_d  = REST;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valve_d = '0;
    if (state_d == OPEN || state_d == RUN || state_d == CLOSE)
      valve_d = N_REQ'(1) << idx_d;
    pump_d  = (state_d == RUN);
    busy_d  = (state_d != IDLE);
    fault_d = (state_d == FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      valve_q  <= '0;
      pump_q   <= 1'b0;
      busy_q   <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      valve_q  <= valve_d;
      pump_q   <= pump_d;
      busy_q   <= busy_d;
      fault_q  <= fault_d;
    end
  end

  assign bus.valve_open = valve_q;
  assign bus.pump_on    = pump_q;
  assign bus.busy       = busy_q;
  assign bus.served_idx = idx_q;
  assign bus.state_dbg  = state_q;
`ifdef PUMP_SCHED_MAXRUN_EN
  assign bus.sched_fault = fault_q;
`else
  assign bus.sched_fault = 1'b0;
`endif

endmodule

// File: tb/tb_pump_scheduler.sv
// Directed bench for pump_scheduler at 1 ms per cycle (SETTLE=2, MIN_RUN=5,
// MIN_REST=3, MAX_RUN=20); watchdog steps depend on PUMP_SCHED_MAXRUN_EN.
module tb_pump_scheduler;
  import pump_sched_pkg::*;

  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk  = 0;
  int   n_pass = 0;

  pump_scheduler_if #(.N_REQ(N)) bus ();

  pump_scheduler #(
    .CLK_HZ          (1000),
    .N_REQ           (N),
    .VALVE_SETTLE_MS (2),
    .MIN_RUN_MS      (5),
    .MIN_REST_MS     (3),
    .MAX_RUN_MS      (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_state(input state_t s, input int budget, input string tag);
    int cnt;
    cnt = 0;
    while (bus.state_dbg != s && cnt < budget) begin
      step(1);
      cnt++;
    end
    chk(tag, 32'(bus.state_dbg), 32'(s));
  endtask

  task automatic serve_one(input logic [1:0] idx);
    int cnt;
    wait_state(OPEN, 40, "rr_open_timeout");
    chk("rr_served_idx", 32'(bus.served_idx), 32'(idx));
    chk("rr_valve", 32'(bus.valve_open), 32'(N'(1) << idx));
    wait_state(RUN, 10, "rr_run_timeout");
    bus.req[idx] = 1'b0;
    cnt = 0;
    while (bus.pump_on && cnt < 50) begin
      cnt++;
      step(1);
    end
    chk("rr_run_len", 32'(cnt), 32'd5);
    wait_state(REST, 10, "rr_rest_timeout");
    bus.req[idx] = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.req       = '0;
    bus.req_fault = '0;
    bus.clr_fault = 1'b0;
    step(2);
    chk("rst_pump",  32'(bus.pump_on),     32'd0);
    chk("rst_valve", 32'(bus.valve_open),  32'd0);
    chk("rst_busy",  32'(bus.busy),        32'd0);
    chk("rst_idx",   32'(bus.served_idx),  32'd0);
    chk("rst_fault", 32'(bus.sched_fault), 32'd0);
    chk("rst_state", 32'(bus.state_dbg),   32'(IDLE));
    rst_n = 1'b1;
    step(2);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Request 0 from IDLE: valve next cycle, pump two cycles later.
    bus.req = 4'b0001;
    step(1);
    chk("t1_valve", 32'(bus.valve_open), 32'h1);
    chk("t1_busy",  32'(bus.busy),       32'd1);
    chk("t1_pump0", 32'(bus.pump_on),    32'd0);
    step(1);
    chk("t1_settle_pump", 32'(bus.pump_on), 32'd0);
    step(1);
    chk("t1_pump_on", 32'(bus.pump_on),   32'd1);
    chk("t1_run",     32'(bus.state_dbg), 32'(RUN));

    // Drop two cycles into RUN: pump held to 5 ms, valve 2 more, rest 3.
    step(2);
    bus.req = '0;
    step(2);
    chk("t2_min_run_hold", 32'(bus.pump_on), 32'd1);
    step(1);
    chk("t2_pump_off",  32'(bus.pump_on),    32'd0);
    chk("t2_close",     32'(bus.state_dbg),  32'(CLOSE));
    chk("t2_valve_hold", 32'(bus.valve_open), 32'h1);
    step(2);
    chk("t2_valve_off", 32'(bus.valve_open), 32'h0);
    chk("t2_rest",      32'(bus.state_dbg),  32'(REST));
    step(2);
    chk("t2_rest_busy", 32'(bus.busy), 32'd1);
    step(1);
    chk("t2_idle", 32'(bus.state_dbg), 32'(IDLE));

    // Pointer now 1: requester 2 is picked, then reset lands mid-RUN.
    bus.req = 4'b0100;
    step(1);
    chk("t6_idx", 32'(bus.served_idx), 32'd2);
    step(2);
    chk("t6_run_pump", 32'(bus.pump_on), 32'd1);
    step(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_pump",  32'(bus.pump_on),    32'd0);
    chk("t6_async_valve", 32'(bus.valve_open), 32'h0);
    chk("t6_async_state", 32'(bus.state_dbg),  32'(IDLE));
    bus.req = '0;
    step(1);
    rst_n = 1'b1;
    step(1);
    chk("t6_idx_cleared", 32'(bus.served_idx), 32'd0);

    // Round robin from pointer 0 over 1011: 0, 1, 3, 0.
    bus.req = 4'b1011;
    serve_one(2'd0);
    serve_one(2'd1);
    serve_one(2'd3);
    serve_one(2'd0);

    // Fault one cycle into RUN aborts at once; fault masks it in IDLE.
    bus.req = 4'b0010;
    wait_state(RUN, 20, "t4_run_timeout");
    chk("t4_idx", 32'(bus.served_idx), 32'd1);
    step(1);
    bus.req_fault = 4'b0010;
    step(1);
    chk("t4_abort_pump",  32'(bus.pump_on),    32'd0);
    chk("t4_abort_state", 32'(bus.state_dbg),  32'(CLOSE));
    chk("t4_abort_valve", 32'(bus.valve_open), 32'h2);
    step(2);
    chk("t4_rest_valve", 32'(bus.valve_open), 32'h0);
    step(7);
    chk("t4_masked_busy",  32'(bus.busy),      32'd0);
    chk("t4_masked_state", 32'(bus.state_dbg), 32'(IDLE));
    bus.req_fault = '0;
    step(1);
    chk("t4_unmask_valve", 32'(bus.valve_open), 32'h2);
    bus.req_fault = 4'b0010;
    step(1);
    chk("t4_open_abort", 32'(bus.state_dbg), 32'(CLOSE));
    chk("t4_open_pump",  32'(bus.pump_on),   32'd0);
    bus.req       = '0;
    bus.req_fault = '0;
    wait_state(IDLE, 20, "t4_idle_timeout");

    // Requester held 25 ms: watchdog trips at 20 ms only when enabled.
    bus.req = 4'b0001;
    wait_state(RUN, 20, "t5_run_timeout");
`ifdef PUMP_SCHED_MAXRUN_EN
    step(19);
    chk("t5_pump_before_limit", 32'(bus.pump_on), 32'd1);
    step(1);
    chk("t5_fault_state", 32'(bus.state_dbg),   32'(FAULT));
    chk("t5_fault_pump",  32'(bus.pump_on),     32'd0);
    chk("t5_fault_valve", 32'(bus.valve_open),  32'h0);
    chk("t5_sched_fault", 32'(bus.sched_fault), 32'd1);
    step(5);
    bus.req = '0;
    chk("t5_fault_latched", 32'(bus.sched_fault), 32'd1);
    bus.clr_fault = 1'b1;
    step(1);
    bus.clr_fault = 1'b0;
    chk("t5_clr_state", 32'(bus.state_dbg),   32'(REST));
    chk("t5_clr_fault", 32'(bus.sched_fault), 32'd0);
`else
    step(24);
    chk("t5_no_wd_pump",  32'(bus.pump_on),     32'd1);
    chk("t5_no_wd_fault", 32'(bus.sched_fault), 32'd0);
    bus.clr_fault = 1'b1;
    step(1);
    bus.clr_fault = 1'b0;
    chk("t5_clr_ignored", 32'(bus.state_dbg), 32'(RUN));
    bus.req = '0;
    wait_state(REST, 20, "t5_rest_timeout");
`endif

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
